// File: rtl/exp_sweep_ctrl.sv
// exp_sweep_ctrl: walks a VARS-input expression through all vectors, captures its truth table and checks it against an expected table
module exp_sweep_ctrl #(
  parameter int VARS = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [(1<<VARS)-1:0]  expected,
  input  logic                  y_in,
  output logic [VARS-1:0]       stim,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<VARS)-1:0]  table_out,
  output logic                  mismatch,
  output logic [VARS:0]         err_count,
  output logic [VARS-1:0]       first_err_idx
);
  localparam int N = 1 << VARS;
  localparam int CW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [VARS-1:0] idx;
  logic [CW-1:0] cnt;
  logic [N-1:0] exp_q;
  logic slot_end, last, accept;
  assign slot_end = cnt == CW'(SETTLE);
  assign last = idx == VARS'(N - 1);
  assign accept = start && state != RUN;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? RUN : IDLE;
      RUN: state_nx = slot_end && last ? FIN : RUN;
      default: state_nx = start ? RUN : IDLE;
    endcase
  end
  always_comb begin
    busy = state == RUN;
    done = state == FIN;
    stim = state == RUN ? idx : '0;
  end
  // y_in is only looked at on the edge that closes a slot, so mid-slot glitches never reach the table
  always_ff @(posedge clk)
    if (rst) begin
      exp_q <= '0;
      table_out <= '0;
      err_count <= '0;
      mismatch <= 1'b0;
      first_err_idx <= '0;
      idx <= '0;
      cnt <= '0;
    end else if (accept) begin
      exp_q <= expected;
      table_out <= '0;
      err_count <= '0;
      mismatch <= 1'b0;
      first_err_idx <= '0;
      idx <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      if (slot_end) begin
        table_out[idx] <= y_in;
        if (y_in != exp_q[idx]) begin
          err_count <= err_count + (VARS+1)'(1);
          if (!mismatch) begin
            first_err_idx <= idx;
            mismatch <= 1'b1;
          end
        end
        idx <= last ? idx : idx + VARS'(1);
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: tb/tb_exp_sweep_ctrl.sv
// tb_exp_sweep_ctrl: table-driven and randomized sweeps checked against a truth-table reference model
module tb_exp_sweep_ctrl;
  logic clk = 1'b0;
  logic rst, start, start2, y_in, y2;
  logic [15:0] expected, expected2, fn, fn2;
  logic [3:0] stim, stim2, fe1, fe2;
  logic busy, done, mm1, busy2, done2, mm2;
  logic [15:0] tbl1, tbl2;
  logic [4:0] ec1, ec2;
  int vectors = 0, miss = 0;

  always #5 clk = ~clk;
  assign y_in = fn[stim];
  assign y2 = fn2[stim2];

  exp_sweep_ctrl #(.VARS(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .y_in(y_in),
    .stim(stim), .busy(busy), .done(done), .table_out(tbl1), .mismatch(mm1),
    .err_count(ec1), .first_err_idx(fe1));

  exp_sweep_ctrl #(.VARS(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start2), .expected(expected2), .y_in(y2),
    .stim(stim2), .busy(busy2), .done(done2), .table_out(tbl2), .mismatch(mm2),
    .err_count(ec2), .first_err_idx(fe2));

  typedef struct {
    logic [15:0] fn;
    logic [15:0] ex;
    logic [15:0] tbl;
    logic mm;
    logic [4:0] ec;
    logic [3:0] fe;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // reference: the captured table is the function itself; errors are the differing bits
  task automatic model_check(input string nm, input logic [15:0] f, input logic [15:0] ex);
    logic [15:0] d;
    int lo;
    d = f ^ ex;
    lo = 0;
    for (int i = 15; i >= 0; i--) if (d[i]) lo = i;
    chk({nm, "_tbl"}, 32'(tbl1), 32'(f));
    chk({nm, "_ec"}, 32'(ec1), $countones(d));
    chk({nm, "_fe"}, 32'(fe1), 32'(lo));
    chk({nm, "_mm"}, 32'(mm1), 32'(d != 0));
  endtask

  // runs one SETTLE=1 sweep; optional start re-pulses and expected toggling while busy
  task automatic sweep(input string nm, input bit perturb, output int lat);
    bit ok;
    logic [15:0] orig;
    int c;
    orig = expected;
    ok = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    c = 0;
    while (!done && c < 100) begin
      if (busy !== 1'b1 || stim !== 4'(c / 2)) ok = 1'b0;
      if (perturb) begin
        start = (c == 5 || c == 20);
        if (c == 10) expected = ~expected;
      end
      tick;
      c++;
    end
    start = 1'b0;
    expected = orig;
    chk({nm, "_stimseq"}, 32'(ok), 1);
    chk({nm, "_latency"}, c, 32);
    lat = c;
  endtask

  initial begin
    vec_t vt[4];
    int lat, c;
    logic [15:0] sv_tbl;
    vt[0] = '{16'hF000, 16'hF000, 16'hF000, 1'b0, 5'd0, 4'd0};
    vt[1] = '{16'hF000, 16'hF001, 16'hF000, 1'b1, 5'd1, 4'd0};
    vt[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 5'd16, 4'd0};
    vt[3] = '{16'h0000, 16'h8000, 16'h0000, 1'b1, 5'd1, 4'd15};
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    expected = '0; expected2 = '0; fn = '0; fn2 = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_outs", {busy, done, stim, tbl1, mm1, ec1, fe1}, 0);
    chk("rst_outs0", {busy2, done2, stim2, tbl2, mm2, ec2, fe2}, 0);

    for (int i = 0; i < 4; i++) begin
      fn = vt[i].fn;
      expected = vt[i].ex;
      sweep($sformatf("vec%0d", i), 1'b0, lat);
      chk($sformatf("vec%0d_tbl", i), 32'(tbl1), 32'(vt[i].tbl));
      chk($sformatf("vec%0d_mm", i), 32'(mm1), 32'(vt[i].mm));
      chk($sformatf("vec%0d_ec", i), 32'(ec1), 32'(vt[i].ec));
      chk($sformatf("vec%0d_fe", i), 32'(fe1), 32'(vt[i].fe));
      tick;
      chk($sformatf("vec%0d_pulse", i), {busy, done}, 0);
    end

    // results must hold while idle
    repeat (5) tick;
    chk("hold_tbl", 32'(tbl1), 32'h0000);
    chk("hold_fe", 32'(fe1), 15);

    // start re-pulses and expected toggling during the sweep are ignored
    fn = 16'hF000;
    expected = 16'hF001;
    sweep("perturb", 1'b1, lat);
    model_check("perturb", 16'hF000, 16'hF001);

    // mid-sweep abort
    fn = 16'hA5C3;
    expected = 16'hA5C3;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_outs", {busy, done, stim, tbl1, mm1, ec1, fe1}, 0);
    c = 0;
    repeat (40) begin
      if (done) c++;
      tick;
    end
    chk("abort_nodone", c, 0);
    sweep("after_abort", 1'b0, lat);
    model_check("after_abort", 16'hA5C3, 16'hA5C3);

    // randomized functions against the reference model
    for (int i = 0; i < 8; i++) begin
      fn = 16'($urandom);
      expected = (i % 2 == 0) ? 16'($urandom) : fn ^ (16'h1 << $urandom_range(15, 0));
      if (i == 7) expected = fn;
      sweep($sformatf("rnd%0d", i), 1'b0, lat);
      model_check($sformatf("rnd%0d", i), fn, expected);
    end

    // SETTLE=0 with start held: back-to-back sweeps through FIN
    fn2 = 16'h1234;
    expected2 = 16'h1230;
    start2 = 1'b1;
    tick;
    c = 0;
    while (!done2 && c < 100) begin
      tick;
      c++;
    end
    chk("s0_first_done", c, 16);
    chk("s0_first_res", {tbl2, mm2, ec2, fe2}, {16'h1234, 1'b1, 5'd1, 4'd2});
    tick;
    c++;
    chk("s0_restart", {busy2, done2, stim2}, {1'b1, 1'b0, 4'd0});
    while (!done2 && c < 100) begin
      tick;
      c++;
    end
    start2 = 1'b0;
    chk("s0_second_done", c, 33);
    sv_tbl = tbl2;
    chk("s0_second_tbl", 32'(sv_tbl), 32'h1234);
    tick;
    chk("s0_idle", {busy2, done2}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
